// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, mode constants and baud divisor helper for the UART blocks
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_CASE = 2'd1;
    localparam logic [1:0] MODE_INC  = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_loopback_fifo_if.sv
// rtl/uart_loopback_fifo_if.sv - serial line, flow control, mode and status bundle of the loopback core
interface uart_loopback_fifo_if;
    logic       RX;
    logic       TX;
    logic       CTS;
    logic       RTS;
    logic [1:0] mode;
    logic [3:0] leds;

    modport slave  (input RX, RTS, mode, output TX, CTS, leds);
    modport master (output RX, RTS, mode, input TX, CTS, leds);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; push and pop in the same cycle always both succeed
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && (!empty || push);
    assign do_push  = push && (!full || pop);
    // An empty FIFO hands the incoming word straight through on a simultaneous push/pop.
    assign pop_data = empty ? push_data : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/uart_loopback_fifo.sv
// rtl/uart_loopback_fifo.sv - UART receiver feeding a FIFO, per-byte transform, and flow-controlled transmitter
module uart_loopback_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 200000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CTS_MARGIN = 4
) (
    input logic                 sys_clk,
    input logic                 rst,
    uart_loopback_fifo_if.slave bus
);
    localparam int DIV  = baud_div(CLK_FREQ, BAUD);
    localparam int CNTW = $clog2(DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int BCW  = $clog2(DATA_BITS);
    localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(DIV - 1);
    localparam logic [CNTW-1:0] CNT_HALF  = CNTW'(DIV / 2);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [BCW-1:0]  LAST_BIT  = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0]  BIT_ONE   = BCW'(1);
    localparam logic [CW-1:0]   CTS_LEVEL = CW'(FIFO_DEPTH - CTS_MARGIN);
    localparam logic [7:0]      DATA_MASK = 8'((1 << DATA_BITS) - 1);

    function automatic logic [7:0] transform(input logic [7:0] b, input logic [1:0] m);
        logic [7:0] r;
        r = b;
        case (m)
            MODE_CASE: if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) r = b ^ 8'h20;
            MODE_INC:  r = (b + 8'd1) & DATA_MASK;
            default:   r = b;
        endcase
        return r;
    endfunction

    logic rx_meta, rx_sync, rx_prev, rts_meta, rts_sync;
    logic rx_fall;

    // RX sync chain resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            {rx_meta, rx_sync, rx_prev} <= 3'b111;
            {rts_meta, rts_sync}        <= 2'b00;
        end else begin
            {rx_meta, rx_sync, rx_prev} <= {bus.RX, rx_meta, rx_sync};
            {rts_meta, rts_sync}        <= {bus.RTS, rts_meta};
        end
    end
    assign rx_fall = rx_prev && !rx_sync;

    uart_state_t          rx_state;
    logic [CNTW-1:0]      rx_cnt;
    logic [BCW-1:0]       rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_push;
    logic                 ferr_sticky;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_state    <= ST_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            rx_push     <= 1'b0;
            ferr_sticky <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            case (rx_state)
                ST_IDLE: if (rx_fall) begin
                    rx_state <= ST_START;
                    rx_cnt   <= CNT_HALF;
                end
                ST_START: if (rx_cnt == '0) begin
                    if (!rx_sync) begin
                        rx_state <= ST_DATA;
                        rx_cnt   <= CNT_FULL;
                        rx_bit   <= '0;
                    end else begin
                        rx_state <= ST_IDLE;
                    end
                end else begin
                    rx_cnt <= rx_cnt - CNT_ONE;
                end
                ST_DATA: if (rx_cnt == '0) begin
                    rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                    rx_cnt   <= CNT_FULL;
                    rx_bit   <= rx_bit + BIT_ONE;
                    if (rx_bit == LAST_BIT) rx_state <= ST_STOP;
                end else begin
                    rx_cnt <= rx_cnt - CNT_ONE;
                end
                ST_STOP: if (rx_cnt == '0) begin
                    if (rx_sync) rx_push <= 1'b1;
                    else         ferr_sticky <= 1'b1;
                    rx_state <= ST_IDLE;
                end else begin
                    rx_cnt <= rx_cnt - CNT_ONE;
                end
            endcase
        end
    end

    logic [7:0]    fifo_data;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          tx_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (sys_clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (8'(rx_shift)),
        .pop       (tx_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    logic ovf_sticky, cts;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            cts        <= 1'b0;
        end else begin
            if (rx_push && fifo_full && !tx_pop) ovf_sticky <= 1'b1;
            cts <= (fifo_count < CTS_LEVEL);
        end
    end

    uart_state_t     tx_state;
    logic [CNTW-1:0] tx_cnt;
    logic [BCW-1:0]  tx_bit;
    logic [7:0]      tx_shift;
    logic            tx_line;

    assign tx_pop = (tx_state == ST_IDLE) && !fifo_empty && rts_sync && (bus.mode != MODE_HOLD);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    tx_line <= 1'b1;
                    if (tx_pop) begin
                        tx_shift <= transform(fifo_data, bus.mode);
                        tx_line  <= 1'b0;
                        tx_cnt   <= CNT_FULL;
                        tx_state <= ST_START;
                    end
                end
                ST_START: if (tx_cnt == '0) begin
                    tx_line  <= tx_shift[0];
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= '0;
                    tx_cnt   <= CNT_FULL;
                    tx_state <= ST_DATA;
                end else begin
                    tx_cnt <= tx_cnt - CNT_ONE;
                end
                ST_DATA: if (tx_cnt == '0) begin
                    tx_cnt <= CNT_FULL;
                    if (tx_bit == LAST_BIT) begin
                        tx_line  <= 1'b1;
                        tx_state <= ST_STOP;
                    end else begin
                        tx_line  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_bit + BIT_ONE;
                    end
                end else begin
                    tx_cnt <= tx_cnt - CNT_ONE;
                end
                ST_STOP: if (tx_cnt == '0) begin
                    tx_state <= ST_IDLE;
                end else begin
                    tx_cnt <= tx_cnt - CNT_ONE;
                end
            endcase
        end
    end

    assign bus.TX   = tx_line;
    assign bus.CTS  = cts;
    assign bus.leds = {ovf_sticky, ferr_sticky, !fifo_empty, tx_state != ST_IDLE};
endmodule

// File: tb/tb_uart_loopback_fifo.sv
// tb/tb_uart_loopback_fifo.sv - self-checking bench: byte-queue model plus per-cycle TX waveform compare
module tb_uart_loopback_fifo;
    localparam int BIT_T = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_loopback_fifo_if bus ();

    uart_loopback_fifo #(
        .CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .CTS_MARGIN(2)
    ) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];
    bit tx_allowed = 1'b1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] model_xform(input logic [7:0] b, input int m);
        logic [7:0] lower;
        lower = b | 8'h20;
        if (m == 1 && lower >= 8'h61 && lower <= 8'h7A) return b ^ 8'h20;
        if (m == 2) return 8'((int'(b) + 1) % 256);
        return b;
    endfunction

    // Line-level sender; the model learns of a good byte as its stop bit begins.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.RX = f[i];
            if (i == 9 && stop_bit && exp_q.size() < DEPTH) exp_q.push_back(b);
            repeat (BIT_T) @(negedge clk);
        end
    endtask

    task automatic expect_log(input logic [7:0] e, input string name);
        logic [7:0] got;
        if (tx_log.size() == 0) begin
            check(1'b0, name, -1, int'(e));
        end else begin
            got = tx_log.pop_front();
            check(got == e, name, int'(got), int'(e));
        end
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.leds[0]) ok = 1'b1;
        end
        check(ok, name, int'(exp_q.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tx_low(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!bus.TX) ok = 1'b1;
        end
        check(ok, name, int'(bus.TX), 0);
    endtask

    // Compare process: every TX frame is checked sample by sample against the queued byte.
    initial begin : tx_monitor
        logic tx_prev;
        logic [9:0] wave;
        logic [7:0] exp_b, got;
        bit aborted;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && tx_prev && bus.TX == 1'b0) begin
                check(tx_allowed, "tx_start_permitted", 1, int'(tx_allowed));
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_frame", 1, 0);
                    exp_b = 8'h00;
                end else begin
                    exp_b = model_xform(exp_q.pop_front(), int'(bus.mode));
                end
                wave = {1'b1, exp_b, 1'b0};
                got = 8'h00;
                aborted = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int s = 0; s < BIT_T && !aborted; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                        end else begin
                            check(bus.TX == wave[b], "tx_wave", int'(bus.TX), int'(wave[b]));
                            if (s == BIT_T / 2 && b >= 1 && b <= 8) got[b-1] = bus.TX;
                        end
                    end
                end
                if (!aborted) tx_log.push_back(got);
            end
            tx_prev = rst ? 1'b1 : bus.TX;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded 100000 cycles");
        $fatal(1);
    end

    initial begin : stimulus
        logic [7:0] flow_bytes [6];
        bit ok;
        flow_bytes = '{8'hC1, 8'h02, 8'h7E, 8'h80, 8'h33, 8'hFE};
        bus.RX = 1'b1;
        bus.RTS = 1'b1;
        bus.mode = 2'd0;

        repeat (3) @(negedge clk);
        check(bus.TX == 1'b1, "reset_tx", int'(bus.TX), 1);
        check(bus.CTS == 1'b0, "reset_cts", int'(bus.CTS), 0);
        check(bus.leds == 4'h0, "reset_leds", int'(bus.leds), 0);
        rst = 1'b0;
        @(negedge clk);
        check(bus.CTS == 1'b1, "cts_after_reset", int'(bus.CTS), 1);

        // Loopback with push-to-start latency
        fork
            send_frame(8'h55, 1'b1);
            begin
                ok = 1'b0;
                for (int i = 0; i < 400 && !ok; i++) begin
                    @(negedge clk);
                    if (bus.leds[1]) ok = 1'b1;
                end
                check(ok, "first_push_seen", int'(bus.leds[1]), 1);
                check(bus.TX == 1'b1, "tx_high_at_push", int'(bus.TX), 1);
                @(negedge clk);
                check(bus.TX == 1'b0, "tx_fall_one_after_push", int'(bus.TX), 0);
                check(bus.leds[1] == 1'b0, "fifo_empty_after_pop", int'(bus.leds[1]), 0);
            end
        join
        send_frame(8'hA3, 1'b1);
        drain("drain_loopback");
        expect_log(8'h55, "loop_byte0");
        expect_log(8'hA3, "loop_byte1");

        // Case toggle and increment wrap
        bus.mode = 2'd1;
        send_frame(8'h61, 1'b1);
        send_frame(8'h5A, 1'b1);
        send_frame(8'h31, 1'b1);
        drain("drain_case");
        expect_log(8'h41, "case_61");
        expect_log(8'h7A, "case_5a");
        expect_log(8'h31, "case_31");
        bus.mode = 2'd2;
        send_frame(8'hFF, 1'b1);
        drain("drain_inc");
        expect_log(8'h00, "inc_ff_wrap");
        bus.mode = 2'd0;

        // Flow control
        bus.RTS = 1'b0;
        tx_allowed = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(flow_bytes[i], 1'b1);
        check(bus.CTS == 1'b1, "cts_at_count5", int'(bus.CTS), 1);
        send_frame(flow_bytes[5], 1'b1);
        check(bus.CTS == 1'b0, "cts_at_count6", int'(bus.CTS), 0);
        check(bus.TX == 1'b1, "tx_held_by_rts", int'(bus.TX), 1);
        bus.RTS = 1'b1;
        tx_allowed = 1'b1;
        wait_tx_low("tx_after_rts");
        check(bus.CTS == 1'b0, "cts_same_cycle_as_pop", int'(bus.CTS), 0);
        @(negedge clk);
        check(bus.CTS == 1'b1, "cts_rises_after_pop", int'(bus.CTS), 1);
        drain("drain_flow");
        for (int i = 0; i < 6; i++) expect_log(flow_bytes[i], "flow_order");

        // Overflow under hold
        bus.mode = 2'd3;
        tx_allowed = 1'b0;
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
        check(bus.leds[3] == 1'b0, "no_ovf_at_full", int'(bus.leds[3]), 0);
        check(bus.CTS == 1'b0, "cts_low_when_full", int'(bus.CTS), 0);
        send_frame(8'h99, 1'b1);
        check(bus.leds[3] == 1'b1, "ovf_sticky_set", int'(bus.leds[3]), 1);
        check(bus.TX == 1'b1, "tx_idle_in_hold", int'(bus.TX), 1);
        bus.mode = 2'd0;
        tx_allowed = 1'b1;
        drain("drain_ovf");
        for (int i = 0; i < 8; i++) expect_log(8'h10 + 8'(i), "ovf_order");
        check(tx_log.size() == 0, "ninth_byte_dropped", tx_log.size(), 0);

        // Framing error, then a short glitch, then recovery
        check(bus.leds[2] == 1'b0, "ferr_clear_before", int'(bus.leds[2]), 0);
        send_frame(8'hA5, 1'b0);
        repeat (20) @(negedge clk);
        check(bus.leds[2] == 1'b1, "ferr_sticky_set", int'(bus.leds[2]), 1);
        check(bus.leds[1] == 1'b0, "ferr_no_push", int'(bus.leds[1]), 0);
        bus.RX = 1'b0;
        repeat (4) @(negedge clk);
        bus.RX = 1'b1;
        repeat (40) @(negedge clk);
        check(bus.leds[1:0] == 2'b00, "glitch_rejected", int'(bus.leds[1:0]), 0);
        send_frame(8'h42, 1'b1);
        drain("drain_recover");
        expect_log(8'h42, "recover_byte");

        // Reset during DATA
        send_frame(8'hFF, 1'b1);
        wait_tx_low("tx_before_reset");
        repeat (2 * BIT_T + BIT_T / 2) @(negedge clk);
        check(bus.leds[0] == 1'b1, "busy_before_reset", int'(bus.leds[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        check(bus.TX == 1'b1, "tx_high_in_reset", int'(bus.TX), 1);
        check(bus.leds == 4'h0, "leds_clear_in_reset", int'(bus.leds), 0);
        check(bus.CTS == 1'b0, "cts_low_in_reset", int'(bus.CTS), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check(bus.CTS == 1'b1, "cts_after_reset_release", int'(bus.CTS), 1);
        repeat (BIT_T * 12) @(negedge clk);
        check(bus.TX == 1'b1, "tx_idle_after_reset", int'(bus.TX), 1);
        check(tx_log.size() == 0, "aborted_frame_not_logged", tx_log.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
